spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 32, SHALL set the bus-ack wait limit in clk cycles (range 4..255).
REQ-002 Parameter STATUS_ID, default 8'h5A, SHALL set the identifier byte of the status word.
REQ-003 clk  input  1  single system clock; all logic SHALL be rising-edge clk.
REQ-004 res  input  1  reset, synchronous and active-high.
REQ-005 nSS  input  1  raw SPI slave select, asynchronous, active-low; frame delimiter.
REQ-006 spi_write  input  1  one-cycle strobe from the SPI16 slave: a 16-bit word was received.
REQ-007 spi_dout  input  16  received word, valid while spi_write=1.
REQ-008 spi_din  output  16  word the SPI16 slave loads for transmission at each word boundary.
REQ-009 bus_addr  output  8  register address.
REQ-010 bus_wdata  output  16  register write data.
REQ-011 bus_we / bus_re  output  1 each  write or read request, held until bus_ack or timeout.
REQ-012 bus_rdata  input  16  read data, valid with bus_ack.
REQ-013 bus_ack  input  1  one-cycle completion strobe.
REQ-014 busy  output  1  high when not IDLE.
REQ-015 err_tmo / err_ovr  output  1 each  sticky timeout and overrun flags.

Function
REQ-016 nSS SHALL pass through a 2-flop synchronizer; "frame active" = synchronized nSS low.
REQ-017 States SHALL be: IDLE, WAIT_WORD, BUS_WR, BUS_RD, DRAIN.
REQ-018 In IDLE, spi_din SHALL equal the status word {STATUS_ID, 6'b0, err_ovr, err_tmo}.
REQ-019 First spi_write of a frame SHALL be the command: bit15 RnW, bit14 INC, bit13 CLR, bits12:8 ignored, bits7:0 start address.
REQ-020 CLR=1 SHALL clear err_tmo and err_ovr in the cycle after the command strobe.
REQ-021 Write command (RnW=0): go to WAIT_WORD. Each later spi_write SHALL go to BUS_WR with bus_wdata=spi_dout and bus_we=1 from the next cycle.
REQ-022 Read command (RnW=1): go directly to BUS_RD, assert bus_re from the next cycle, and prefetch.
REQ-023 On bus_ack in BUS_RD: spi_din SHALL take bus_rdata in the same edge, then go to WAIT_WORD.
REQ-024 Each later spi_write in a read frame SHALL start the next BUS_RD.
REQ-025 Read latency: the master sends cmd, one dummy word, then receives reg[addr] in word 2, reg[addr+INC] in word 3, and so on.
REQ-026 After each completed bus cycle, bus_addr SHALL increment by 1 if INC=1, modulo 256 (8'hFF wraps to 8'h00); otherwise it SHALL hold.
REQ-027 Timeout: if TIMEOUT cycles pass in BUS_WR/BUS_RD without bus_ack, the request SHALL drop and err_tmo SHALL set. For a read, spi_din SHALL become 16'hDEAD. The FSM SHALL proceed as if acked.
REQ-028 spi_write arriving in BUS_WR/BUS_RD SHALL set err_ovr and the word SHALL be discarded; the bus cycle SHALL continue.
REQ-029 A frame end (synchronized nSS high) in WAIT_WORD SHALL return to IDLE next cycle.
REQ-030 A frame end in BUS_WR/BUS_RD SHALL go to DRAIN. DRAIN SHALL hold the request until ack or timeout, then go to IDLE, with no address increment.
REQ-031 bus_we and bus_re SHALL never be high together. Each SHALL deassert in the cycle after ack.
REQ-032 spi_write while the frame is inactive SHALL be ignored.

Reset
REQ-033 On res: state IDLE, spi_din = status word with flags 0, bus_addr 0, bus_wdata 0, bus_we 0, bus_re 0, busy 0, err_tmo 0, err_ovr 0, timeout counter 0, synchronizer flops 1.
REQ-034 res mid-bus-cycle SHALL drop the request immediately, with no DRAIN.

Structure
REQ-035 Package spi_reg_pkg SHALL hold: the state encoding, command bit positions (RNW=15, INC=14, CLR=13), the STATUS_ID default, and constant 16'hDEAD.
REQ-036 The nSS synchronizer SHALL be sub-module sync2; the rest SHALL stay flat.

Verification
REQ-037 Write burst: cmd 16'h4010 + 3 words 1111/2222/3333, ack after 2 cycles -> writes to 0x10, 0x11, 0x12 with those data; busy falls 1 cycle after nSS high.
REQ-038 Read burst: cmd 16'hC0FE, regs FE=ABCD, FF=1234, 00=5678, 4 dummy words -> MISO words: status, ABCD, 1234, 5678; address wraps FF->00.
REQ-039 Timeout: read cmd 16'h8005, bus_ack never -> bus_re drops after 32 cycles, err_tmo=1, next word DEAD, status word = 5A01.
REQ-040 Overrun: second spi_write during BUS_WR (ack delayed 20 cycles) -> err_ovr=1, only first word written; cmd 16'h2000 then clears both flags.
REQ-041 Abort: nSS high during BUS_RD -> DRAIN until ack, then IDLE; bus_addr unchanged. res asserted during BUS_WR -> bus_we 0 next cycle.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared definitions for the SPI-to-register-bus bridge: FSM state encoding,
// command word bit positions, the default status identifier, the read-timeout
// filler word and a helper that assembles the status word.
// -----------------------------------------------------------------------------
package spi_reg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_WORD = 3'd1,
      ST_BUS_WR    = 3'd2,
      ST_BUS_RD    = 3'd3,
      ST_DRAIN     = 3'd4
   } state_e;

   // Command word layout: [15] RnW, [14] INC, [13] CLR, [12:8] unused, [7:0] addr
   localparam int CMD_RNW = 15;
   localparam int CMD_INC = 14;
   localparam int CMD_CLR = 13;

   localparam logic [7:0]  STATUS_ID_DEF = 8'h5A;
   localparam logic [15:0] TMO_WORD      = 16'hDEAD;

   // Status word returned to the master while the bridge is idle
   function automatic logic [15:0] status_word(input logic [7:0] id,
                                               input logic       ovr,
                                               input logic       tmo);
      return {id, 6'b000000, ovr, tmo};
   endfunction

endpackage

// File: rtl/spi_reg_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous level. Both stages reset to
// 1 so an active-low select reads as inactive while in reset.
// Ports:
//   clk  in   system clock
//   res  in   synchronous active-high reset
//   d    in   asynchronous input level
//   q    out  synchronized level
// -----------------------------------------------------------------------------
module sync2 (
   input  logic clk,
   input  logic res,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk) begin
      if (res) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
// Bridges a 16-bit SPI slave to a simple request/ack register bus. The first
// word of a frame is a command (RnW, INC, CLR, start address); following words
// are write data or read pacing words. Reads are prefetched so the master sees
// reg[addr] two words after the command.
// Ports:
//   clk, res             clock, synchronous active-high reset
//   nSS                  raw async slave select (active low), frame delimiter
//   spi_write, spi_dout  received-word strobe and word
//   spi_din              word loaded by the SPI slave at each word boundary
//   bus_addr/bus_wdata   register address / write data
//   bus_we/bus_re        write / read request, held until ack or timeout
//   bus_rdata, bus_ack   read data and one-cycle completion strobe
//   busy                 high whenever the FSM is not idle
//   err_tmo/err_ovr      sticky timeout / overrun flags
// -----------------------------------------------------------------------------
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int unsigned TIMEOUT   = 32,
   parameter logic [7:0]  STATUS_ID = STATUS_ID_DEF
) (
   input  logic        clk,
   input  logic        res,
   input  logic        nSS,
   input  logic        spi_write,
   input  logic [15:0] spi_dout,
   output logic [15:0] spi_din,
   output logic [7:0]  bus_addr,
   output logic [15:0] bus_wdata,
   output logic        bus_we,
   output logic        bus_re,
   input  logic [15:0] bus_rdata,
   input  logic        bus_ack,
   output logic        busy,
   output logic        err_tmo,
   output logic        err_ovr
);

   // Last count value before the request is abandoned
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

   state_e      state_q,    state_d;
   logic        rd_frame_q, rd_frame_d;
   logic        inc_q,      inc_d;
   logic [7:0]  addr_q,     addr_d;
   logic [15:0] wdata_q,    wdata_d;
   logic        we_q,       we_d;
   logic        re_q,       re_d;
   logic        busy_q,     busy_d;
   logic        err_tmo_q,  err_tmo_d;
   logic        err_ovr_q,  err_ovr_d;
   logic [7:0]  tmo_cnt_q,  tmo_cnt_d;
   logic [15:0] spi_din_q,  spi_din_d;
   logic [15:0] spi_din_nxt_s;

   logic nss_sync_s;
   logic frame_act_s;
   logic word_s;
   logic tmo_hit_s;

   sync2 u_nss_sync (
      .clk (clk),
      .res (res),
      .d   (nSS),
      .q   (nss_sync_s)
   );

   assign frame_act_s = ~nss_sync_s;
   // Words received outside a frame are ignored everywhere
   assign word_s      = spi_write & frame_act_s;
   assign tmo_hit_s   = (tmo_cnt_q == TMO_LAST) & ~bus_ack;

   // Next-state and next-output computation for the bridge FSM
   always_comb begin
      state_d       = state_q;
      rd_frame_d    = rd_frame_q;
      inc_d         = inc_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      we_d          = we_q;
      re_d          = re_q;
      err_tmo_d     = err_tmo_q;
      err_ovr_d     = err_ovr_q;
      tmo_cnt_d     = 8'd0;
      spi_din_nxt_s = spi_din_q;

      case (state_q)
         ST_IDLE: begin
            if (word_s) begin
               rd_frame_d = spi_dout[CMD_RNW];
               inc_d      = spi_dout[CMD_INC];
               addr_d     = spi_dout[7:0];
               if (spi_dout[CMD_CLR]) begin
                  err_tmo_d = 1'b0;
                  err_ovr_d = 1'b0;
               end else begin
                  err_tmo_d = err_tmo_q;
                  err_ovr_d = err_ovr_q;
               end
               // Reads start the prefetch straight from the command word
               if (spi_dout[CMD_RNW]) begin
                  state_d = ST_BUS_RD;
                  re_d    = 1'b1;
               end else begin
                  state_d = ST_WAIT_WORD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_WAIT_WORD: begin
            if (!frame_act_s) begin
               state_d = ST_IDLE;
            end else if (word_s) begin
               if (rd_frame_q) begin
                  state_d = ST_BUS_RD;
                  re_d    = 1'b1;
               end else begin
                  state_d = ST_BUS_WR;
                  we_d    = 1'b1;
                  wdata_d = spi_dout;
               end
            end else begin
               state_d = ST_WAIT_WORD;
            end
         end

         ST_BUS_WR, ST_BUS_RD: begin
            // A word during an open bus cycle is dropped and flagged
            if (word_s) begin
               err_ovr_d = 1'b1;
            end else begin
               err_ovr_d = err_ovr_q;
            end
            // Ack takes priority over a simultaneous frame end
            if (bus_ack || tmo_hit_s) begin
               we_d      = 1'b0;
               re_d      = 1'b0;
               state_d   = ST_WAIT_WORD;
               addr_d    = inc_q ? (addr_q + 8'd1) : addr_q;
               err_tmo_d = err_tmo_q | tmo_hit_s;
               if (state_q == ST_BUS_RD) begin
                  spi_din_nxt_s = bus_ack ? bus_rdata : TMO_WORD;
               end else begin
                  spi_din_nxt_s = spi_din_q;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
               state_d   = frame_act_s ? state_q : ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Finish the abandoned bus cycle without advancing the address
            if (bus_ack || tmo_hit_s) begin
               we_d      = 1'b0;
               re_d      = 1'b0;
               state_d   = ST_IDLE;
               err_tmo_d = err_tmo_q | tmo_hit_s;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            we_d    = 1'b0;
            re_d    = 1'b0;
         end
      endcase
   end

   // Idle always presents the live status word; otherwise keep FSM choice
   assign spi_din_d = (state_d == ST_IDLE) ? status_word(STATUS_ID, err_ovr_d, err_tmo_d)
                                           : spi_din_nxt_s;
   assign busy_d    = (state_d != ST_IDLE);

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (res) begin
         state_q    <= ST_IDLE;
         rd_frame_q <= 1'b0;
         inc_q      <= 1'b0;
         addr_q     <= 8'd0;
         wdata_q    <= 16'd0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         busy_q     <= 1'b0;
         err_tmo_q  <= 1'b0;
         err_ovr_q  <= 1'b0;
         tmo_cnt_q  <= 8'd0;
         spi_din_q  <= status_word(STATUS_ID, 1'b0, 1'b0);
      end else begin
         state_q    <= state_d;
         rd_frame_q <= rd_frame_d;
         inc_q      <= inc_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         re_q       <= re_d;
         busy_q     <= busy_d;
         err_tmo_q  <= err_tmo_d;
         err_ovr_q  <= err_ovr_d;
         tmo_cnt_q  <= tmo_cnt_d;
         spi_din_q  <= spi_din_d;
      end
   end

   assign spi_din   = spi_din_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_we    = we_q;
   assign bus_re    = re_q;
   assign busy      = busy_q;
   assign err_tmo   = err_tmo_q;
   assign err_ovr   = err_ovr_q;

endmodule
